// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC controller: state encoding and widths.
package adc_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    SAMPLE  = 2'b01,
    CONVERT = 2'b10,
    DONE    = 2'b11
  } state_e;

endpackage

// File: rtl/sar_register.sv
// Trial-code register and bit index for the binary search.
// The FSM drives one operation per cycle: clear, load MSB, or resolve the current bit.
module sar_register #(
  parameter int WIDTH = 12,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             clear_i,
  input  logic             load_msb_i,
  input  logic             resolve_i,
  input  logic             cmp_i,
  output logic [WIDTH-1:0] code_o,
  output logic [WIDTH-1:0] resolved_o,
  output logic             last_o
);

  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH-1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [WIDTH-1:0] code_q, code_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] resolved;

  // Current code with the bit under test replaced by the comparator verdict.
  always_comb begin
    resolved         = code_q;
    resolved[idx_q]  = cmp_i;
  end

  always_comb begin
    code_d = code_q;
    idx_d  = idx_q;
    if (clear_i) begin
      code_d = '0;
      idx_d  = '0;
    end else if (load_msb_i) begin
      code_d = MSB_CODE;
      idx_d  = IDX_TOP;
    end else if (resolve_i) begin
      code_d = resolved;
      if (idx_q != '0) begin
        code_d[idx_q - IDX_ONE] = 1'b1;
        idx_d                   = idx_q - IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      code_q <= '0;
      idx_q  <= '0;
    end else begin
      code_q <= code_d;
      idx_q  <= idx_d;
    end
  end

  assign code_o     = code_q;
  assign resolved_o = resolved;
  assign last_o     = (idx_q == '0);

endmodule

// File: rtl/sar_adc_controller.sv
// SAR conversion FSM: sample, WIDTH-cycle binary search on the DAC, one-cycle ack.
// en_ low converts continuously; en_ high in SAMPLE/CONVERT aborts without touching data.
module sar_adc_controller
  import adc_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               en_,
  input  logic               comparator,
  output logic               sample_and_hold,
  output logic               dac_en,
  output logic               ack,
  output logic [WIDTH-1:0]   dac,
  output logic [WIDTH-1:0]   data,
  output logic [STATE_W-1:0] state_dbg
);

  state_e           state, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sar_clear, sar_load_msb, sar_resolve, sar_last;
  logic [WIDTH-1:0] sar_code, sar_resolved;

  sar_register #(.WIDTH(WIDTH)) u_sar (
    .clk        (clk),
    .reset_     (reset_),
    .clear_i    (sar_clear),
    .load_msb_i (sar_load_msb),
    .resolve_i  (sar_resolve),
    .cmp_i      (comparator),
    .code_o     (sar_code),
    .resolved_o (sar_resolved),
    .last_o     (sar_last)
  );

  always_comb begin
    state_d      = state;
    data_d       = data_q;
    sar_clear    = 1'b0;
    sar_load_msb = 1'b0;
    sar_resolve  = 1'b0;
    unique case (state)
      IDLE: begin
        sar_clear = 1'b1;
        if (!en_) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (en_) begin
          sar_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          sar_load_msb = 1'b1;
          state_d      = CONVERT;
        end
      end
      CONVERT: begin
        if (en_) begin
          sar_clear = 1'b1;
          state_d   = IDLE;
        end else begin
          sar_resolve = 1'b1;
          if (sar_last) begin
            data_d  = sar_resolved;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // Clear the trial code so SAMPLE and IDLE both present dac = 0.
        sar_clear = 1'b1;
        state_d   = en_ ? IDLE : SAMPLE;
      end
      default: begin
        sar_clear = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state  <= IDLE;
      data_q <= '0;
    end else begin
      state  <= state_d;
      data_q <= data_d;
    end
  end

  assign sample_and_hold = (state == SAMPLE);
  assign dac_en          = (state == CONVERT);
  assign ack             = (state == DONE);
  assign dac             = sar_code;
  assign data            = data_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed bench for sar_adc_controller with an ideal comparator model (analog >= dac).
module tb_sar_adc_controller;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset_ = 1'b0;
  logic         en_ = 1'b1;
  logic         comparator;
  logic         sample_and_hold, dac_en, ack;
  logic [W-1:0] dac, data;
  logic [1:0]   state_dbg;

  logic [W-1:0] analog = '0;
  int           stuck = 0;  // 0 = ideal, 1 = stuck high, 2 = stuck low

  int checks = 0;
  int errors = 0;

  sar_adc_controller #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset_          (reset_),
    .en_             (en_),
    .comparator      (comparator),
    .sample_and_hold (sample_and_hold),
    .dac_en          (dac_en),
    .ack             (ack),
    .dac             (dac),
    .data            (data),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;

  always_comb begin
    comparator = 1'b0;
    case (stuck)
      1:       comparator = 1'b1;
      2:       comparator = 1'b0;
      default: comparator = (analog >= dac);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-shot conversion from IDLE; returns edges from request to ack (bounded).
  task automatic run_conv(input logic [W-1:0] val, input int mode, output int lat);
    bit found;
    @(negedge clk);
    analog = val;
    stuck  = mode;
    en_    = 1'b0;
    lat    = 0;
    found  = 0;
    while (!found && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack) found = 1;
    end
    check("ack_seen", found, 1);
    en_ = 1'b1;
  endtask

  task automatic count_acks(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ack) n++;
    end
  endtask

  initial begin
    int lat, n, cnt, sum;
    bit stable;
    logic [W-1:0] vals[16];
    int noise[8];

    // Reset state
    #20;
    check("rst_state", state_dbg, 2'b00);
    check("rst_data", data, 0);
    check("rst_dac", dac, 0);
    check("rst_ack", ack, 0);
    check("rst_sah", sample_and_hold, 0);
    check("rst_dacen", dac_en, 0);
    reset_ = 1'b1;

    // Single conversions, including both boundaries
    run_conv(12'hA5C, 0, lat);
    check("lat_a5c", lat, 14);
    check("data_a5c", data, 12'hA5C);
    @(negedge clk);
    check("ack_one_cycle", ack, 0);
    check("idle_dac", dac, 0);
    run_conv(12'h000, 0, lat);
    check("data_000", data, 12'h000);
    run_conv(12'hFFF, 0, lat);
    check("data_fff", data, 12'hFFF);

    // Continuous: 1234 then 3000, data stable during second conversion
    @(negedge clk);
    @(negedge clk);
    analog = 12'd1234;
    en_    = 1'b0;
    cnt    = 0;
    while (!ack && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) check("sah_in_sample", sample_and_hold, 1);
      if (cnt == 2) check("dacen_in_convert", dac_en, 1);
      if (cnt == 2) check("msb_trial", dac, 12'h800);
    end
    check("cont_lat1", cnt, 14);
    check("cont_data1", data, 1234);
    analog = 12'd3000;
    cnt    = 0;
    stable = 1;
    do begin
      @(negedge clk);
      cnt++;
      if (!ack && data !== 12'd1234) stable = 0;
    end while (!ack && cnt < 40);
    check("cont_period", cnt, 14);
    check("cont_stable", stable, 1);
    check("cont_data2", data, 3000);
    en_ = 1'b1;
    @(negedge clk);
    check("cont_to_idle", state_dbg, 2'b00);

    // Oversampling: symmetric noise pairs around base 2000
    for (int i = 0; i < 8; i++) begin
      noise[i]       = int'($urandom_range(0, 4)) - 2;
      vals[2*i]      = W'(2000 + noise[i]);
      vals[2*i + 1]  = W'(2000 - noise[i]);
    end
    sum = 0;
    stable = 1;
    @(negedge clk);
    analog = vals[0];
    en_    = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!ack && cnt < 40);
      if (!ack || data !== vals[k]) stable = 0;
      sum += int'(data);
      if (k < 15) analog = vals[k + 1];
    end
    en_ = 1'b1;
    check("os_each_exact", stable, 1);
    check("os_mean", ((sum / 16) >= 1999) && ((sum / 16) <= 2001), 1);

    // Reset mid-conversion
    @(negedge clk);
    @(negedge clk);
    analog = 12'd3333;
    en_    = 1'b0;
    repeat (2) @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_convert", state_dbg, 2'b10);
    reset_ = 1'b0;
    #1;
    check("midrst_state", state_dbg, 2'b00);
    check("midrst_data", data, 0);
    check("midrst_dac", dac, 0);
    en_ = 1'b1;
    #10;
    reset_ = 1'b1;
    run_conv(12'd777, 0, lat);
    check("post_rst_777", data, 777);

    // Abort mid-conversion
    @(negedge clk);
    @(negedge clk);
    analog = 12'd500;
    en_    = 1'b0;
    repeat (2) @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    en_ = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", state_dbg, 2'b00);
    check("abort_dac", dac, 0);
    count_acks(20, n);
    check("abort_no_ack", n, 0);
    check("abort_data", data, 777);

    // Stuck comparators
    run_conv(12'd100, 1, lat);
    check("stuck1_data", data, 12'hFFF);
    count_acks(20, n);
    check("stuck1_one_ack", n, 0);
    run_conv(12'd100, 2, lat);
    check("stuck0_data", data, 12'h000);
    count_acks(20, n);
    check("stuck0_one_ack", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
